// File: rtl/wb_sram_mp.sv
// Multi-port Wishbone B3 SRAM slave: NPORTS ports share one single-port array through a
// round-robin arbiter, with classic cycles and linear/wrap incrementing bursts.
module wb_sram_mp #(
  parameter int    NPORTS        = 2,
  parameter int    MEM_SIZE_BYTE = 'h8000,
  parameter string MEM_FILE      = "sram.vmem",
  parameter int    AW            = $clog2(MEM_SIZE_BYTE),
  parameter int    DW            = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NPORTS*AW-1:0] wb_adr_i,
  input  logic [NPORTS*2-1:0]  wb_bte_i,
  input  logic [NPORTS*3-1:0]  wb_cti_i,
  input  logic [NPORTS-1:0]    wb_cyc_i,
  input  logic [NPORTS-1:0]    wb_stb_i,
  input  logic [NPORTS-1:0]    wb_we_i,
  input  logic [NPORTS*(DW/8)-1:0] wb_sel_i,
  input  logic [NPORTS*DW-1:0] wb_dat_i,
  output logic [NPORTS-1:0]    wb_ack_o,
  output logic [NPORTS-1:0]    wb_err_o,
  output logic [NPORTS-1:0]    wb_rty_o,
  output logic [NPORTS*DW-1:0] wb_dat_o
);

  localparam int SW        = DW / 8;
  localparam int BYTE_AW   = SW >> 1;
  localparam int WORD_AW   = AW - BYTE_AW;
  localparam int MEM_WORDS = MEM_SIZE_BYTE / SW;
  localparam int OW        = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [AW:0] ADR_LIMIT = (AW+1)'(MEM_SIZE_BYTE);

  typedef enum logic [1:0] {IDLE, FETCH, XFER, ERR} state_e;

  state_e             state_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      last_owner_q;
  logic [WORD_AW-1:0] addr_q;
  logic [DW-1:0]      dout_q;
  logic [NPORTS-1:0]  err_q;

  logic [DW-1:0] mem [MEM_WORDS];

  logic [AW-1:0] adr [NPORTS];
  logic [1:0]    bte [NPORTS];
  logic [2:0]    cti [NPORTS];
  logic [SW-1:0] sel [NPORTS];
  logic [DW-1:0] dat [NPORTS];

  logic [NPORTS-1:0]  req;
  logic [NPORTS-1:0]  own_onehot;
  logic [OW-1:0]      win;
  logic               win_oor;
  logic               own_cyc, own_stb, own_we;
  logic [1:0]         own_bte;
  logic [2:0]         own_cti;
  logic [SW-1:0]      own_sel;
  logic [DW-1:0]      own_dat;
  logic [WORD_AW-1:0] wrap_mask;
  logic [WORD_AW-1:0] addr_inc;
  logic [WORD_AW-1:0] addr_nxt;
  logic               mem_we;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      adr[p] = wb_adr_i[p*AW +: AW];
      bte[p] = wb_bte_i[p*2 +: 2];
      cti[p] = wb_cti_i[p*3 +: 3];
      sel[p] = wb_sel_i[p*SW +: SW];
      dat[p] = wb_dat_i[p*DW +: DW];
    end
  end

  assign req = wb_cyc_i & wb_stb_i;

  // Search starts one past the previous owner so every waiting port is reached in turn.
  always_comb begin
    win = '0;
    for (int i = NPORTS; i >= 1; i--) begin
      if (req[(int'(last_owner_q) + i) % NPORTS]) begin
        win = OW'((int'(last_owner_q) + i) % NPORTS);
      end
    end
  end

  assign win_oor = {1'b0, adr[win]} >= ADR_LIMIT;

  assign own_cyc    = wb_cyc_i[owner_q];
  assign own_stb    = wb_stb_i[owner_q];
  assign own_we     = wb_we_i[owner_q];
  assign own_bte    = bte[owner_q];
  assign own_cti    = cti[owner_q];
  assign own_sel    = sel[owner_q];
  assign own_dat    = dat[owner_q];
  assign own_onehot = NPORTS'(1) << owner_q;

  // Wrap bursts only advance the masked low bits; linear uses an all-ones mask.
  always_comb begin
    case (own_bte)
      2'b01:   wrap_mask = WORD_AW'(3);
      2'b10:   wrap_mask = WORD_AW'(7);
      2'b11:   wrap_mask = WORD_AW'(15);
      default: wrap_mask = '1;
    endcase
    addr_inc = addr_q + WORD_AW'(1);
    addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
  end

  assign mem_we = (state_q == XFER) && own_cyc && own_stb && own_we;

  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (own_sel[b]) mem[addr_q][b*8 +: 8] <= own_dat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NPORTS - 1);
      addr_q       <= '0;
      dout_q       <= '0;
      err_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= win;
            addr_q  <= adr[win][AW-1:BYTE_AW];
            state_q <= win_oor ? ERR : FETCH;
          end
        end
        FETCH: begin
          if (!own_we) dout_q <= mem[addr_q];
          state_q <= XFER;
        end
        XFER: begin
          if (!own_cyc) begin
            state_q      <= IDLE;
            last_owner_q <= owner_q;
          end else if (own_stb) begin
            if (own_cti == 3'b010) begin
              addr_q <= addr_nxt;
              if (!own_we) dout_q <= mem[addr_nxt];
            end else begin
              state_q      <= IDLE;
              last_owner_q <= owner_q;
            end
          end
        end
        ERR: begin
          // First ERR cycle lines err up with the ack latency; the second drives it.
          if (err_q == '0) begin
            err_q <= own_onehot;
          end else begin
            err_q        <= '0;
            state_q      <= IDLE;
            last_owner_q <= owner_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_ack_o = (state_q == XFER && own_cyc && own_stb) ? own_onehot : '0;
  assign wb_err_o = err_q;
  assign wb_rty_o = '0;
  assign wb_dat_o = {NPORTS{dout_q}};

endmodule

// File: tb/tb_wb_sram_mp.sv
// Directed self-checking bench for wb_sram_mp (two ports, 0x6000-byte array, AW=15).
module tb_wb_sram_mp;

  localparam int NP = 2;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP*AW-1:0] adr;
  logic [NP*2-1:0]  bte;
  logic [NP*3-1:0]  cti;
  logic [NP-1:0]    cyc, stb, we;
  logic [NP*SW-1:0] sel;
  logic [NP*DW-1:0] dati;
  logic [NP-1:0]    ack, err, rty;
  logic [NP*DW-1:0] dato;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_sram_mp #(
    .NPORTS(2), .MEM_SIZE_BYTE('h6000), .MEM_FILE(""), .AW(15), .DW(32)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wb_adr_i(adr), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_dat_i(dati),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(dato)
  );

  task automatic drive(input int p, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [1:0] b, input logic [2:0] t,
                       input logic [3:0] sl, input logic [31:0] d);
    cyc[p] = c;
    stb[p] = s;
    we[p]  = w;
    adr[p*AW +: AW] = a;
    bte[p*2 +: 2]   = b;
    cti[p*3 +: 3]   = t;
    sel[p*SW +: SW] = sl;
    dati[p*DW +: DW] = d;
  endtask

  task automatic rel(input int p);
    drive(p, 1'b0, 1'b0, 1'b0, '0, 2'b00, 3'b000, 4'h0, 32'h0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Fixed-latency classic write used for preloading; starts and ends in IDLE.
  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
    drive(p, 1'b1, 1'b1, 1'b1, a, 2'b00, 3'b000, sl, d);
    step; step; step;
    rel(p);
  endtask

  task automatic test_reset;
    logic [1:0] exp;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 15'h0000, 2'b00, 3'b000, 4'hf, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 15'h0004, 2'b00, 3'b000, 4'hf, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack got %b want 00", ack); end
    checks++; if (err !== 2'b00) begin errors++; $display("[TB] FAIL reset_err got %b want 00", err); end
    checks++; if (rty !== 2'b00) begin errors++; $display("[TB] FAIL reset_rty got %b want 00", rty); end
    checks++; if (dato !== '0) begin errors++; $display("[TB] FAIL reset_dat got %h want 0", dato); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp = (c == 2) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
      @(negedge clk);
      checks++;
      if (ack !== exp) begin errors++; $display("[TB] FAIL reset_first_grant c%0d got %b want %b", c, ack, exp); end
      step;
      if (c == 2) rel(0);
      if (c == 5) rel(1);
    end
  endtask

  task automatic test_classic_write_read;
    logic [1:0] exp;
    wr(0, 15'h0010, 32'h11223344, 4'hf);
    drive(0, 1'b1, 1'b1, 1'b1, 15'h0010, 2'b00, 3'b000, 4'b0101, 32'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      exp = (c == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      checks++;
      if (ack !== exp) begin errors++; $display("[TB] FAIL wr_ack c%0d got %b want %b", c, ack, exp); end
      step;
    end
    rel(0);
    drive(0, 1'b1, 1'b1, 1'b0, 15'h0010, 2'b00, 3'b000, 4'hf, 32'h0);
    for (int c = 0; c < 3; c++) begin
      exp = (c == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      checks++;
      if (ack !== exp) begin errors++; $display("[TB] FAIL rd_ack c%0d got %b want %b", c, ack, exp); end
      if (c == 2) begin
        checks++;
        if (dato !== {2{32'h11AD33EF}}) begin errors++; $display("[TB] FAIL rd_data got %h want %h", dato, {2{32'h11AD33EF}}); end
      end
      step;
    end
    rel(0);
  endtask

  task automatic test_wrap4;
    logic [31:0] exp_dat [4];
    exp_dat = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    for (int i = 0; i < 8; i++) wr(0, AW'(4*i), 32'hA0 + 32'(i), 4'hf);
    drive(1, 1'b1, 1'b1, 1'b0, 15'h0008, 2'b01, 3'b010, 4'hf, 32'h0);
    step; step;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cti[1*3 +: 3] = 3'b111;
      @(negedge clk);
      checks++;
      if (ack !== 2'b10 || dato[31:0] !== exp_dat[k]) begin
        errors++;
        $display("[TB] FAIL wrap4 beat%0d got ack %b dat %h want ack 10 dat %h", k, ack, dato[31:0], exp_dat[k]);
      end
      step;
    end
    rel(1);
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp;
    logic [31:0] exp_dat;
    drive(0, 1'b1, 1'b1, 1'b0, 15'h0000, 2'b00, 3'b000, 4'hf, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 15'h0004, 2'b00, 3'b000, 4'hf, 32'h0);
    for (int c = 0; c < 12; c++) begin
      exp = (c % 3 != 2) ? 2'b00 : (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
      exp_dat = (exp == 2'b01) ? 32'hA0 : 32'hA1;
      @(negedge clk);
      checks++;
      if (ack !== exp) begin errors++; $display("[TB] FAIL rr_ack c%0d got %b want %b", c, ack, exp); end
      if (exp != 2'b00) begin
        checks++;
        if (dato[31:0] !== exp_dat) begin errors++; $display("[TB] FAIL rr_data c%0d got %h want %h", c, dato[31:0], exp_dat); end
      end
      step;
    end
    rel(0);
    rel(1);
  endtask

  task automatic test_back_to_back;
    logic [1:0]  exp;
    logic [31:0] exp_dat;
    drive(0, 1'b1, 1'b1, 1'b0, 15'h0008, 2'b00, 3'b000, 4'hf, 32'h0);
    for (int c = 0; c < 6; c++) begin
      exp = (c == 2 || c == 5) ? 2'b01 : 2'b00;
      exp_dat = (c == 2) ? 32'hA2 : 32'hA3;
      @(negedge clk);
      checks++;
      if (ack !== exp) begin errors++; $display("[TB] FAIL b2b_ack c%0d got %b want %b", c, ack, exp); end
      if (exp != 2'b00) begin
        checks++;
        if (dato[31:0] !== exp_dat) begin errors++; $display("[TB] FAIL b2b_data c%0d got %h want %h", c, dato[31:0], exp_dat); end
      end
      step;
      if (c == 2) drive(0, 1'b1, 1'b1, 1'b0, 15'h000C, 2'b00, 3'b000, 4'hf, 32'h0);
    end
    rel(0);
  endtask

  task automatic test_wait_abort;
    logic [1:0]  ea [12];
    logic [31:0] ed [12];
    ea = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    ed = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA2, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h0, 32'hA5};
    drive(0, 1'b1, 1'b1, 1'b0, 15'h0000, 2'b00, 3'b010, 4'hf, 32'h0);
    for (int c = 0; c < 12; c++) begin
      if (c == 4) stb[0] = 1'b0;
      if (c == 6) stb[0] = 1'b1;
      if (c == 8) cyc[0] = 1'b0;
      if (c == 9) begin
        rel(0);
        drive(1, 1'b1, 1'b1, 1'b0, 15'h0014, 2'b00, 3'b000, 4'hf, 32'h0);
      end
      @(negedge clk);
      checks++;
      if (ack !== ea[c]) begin errors++; $display("[TB] FAIL wait_abort_ack c%0d got %b want %b", c, ack, ea[c]); end
      if (ed[c] != 32'h0) begin
        checks++;
        if (dato[31:0] !== ed[c]) begin errors++; $display("[TB] FAIL wait_abort_data c%0d got %h want %h", c, dato[31:0], ed[c]); end
      end
      step;
    end
    rel(1);
  endtask

  task automatic test_out_of_range;
    logic [1:0] exp;
    wr(0, 15'h3000, 32'h12345678, 4'hf);
    drive(0, 1'b1, 1'b1, 1'b1, 15'h7000, 2'b00, 3'b000, 4'hf, 32'h55555555);
    for (int c = 0; c < 4; c++) begin
      exp = (c == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      checks++;
      if (err !== exp || ack !== 2'b00) begin
        errors++;
        $display("[TB] FAIL oor c%0d got err %b ack %b want err %b ack 00", c, err, ack, exp);
      end
      step;
      if (c == 2) rel(0);
    end
    drive(0, 1'b1, 1'b1, 1'b0, 15'h3000, 2'b00, 3'b000, 4'hf, 32'h0);
    step; step;
    @(negedge clk);
    checks++;
    if (ack !== 2'b01 || dato[31:0] !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL oor_unchanged got ack %b dat %h want ack 01 dat 12345678", ack, dato[31:0]);
    end
    step;
    rel(0);
  endtask

  task automatic test_async_reset;
    drive(1, 1'b1, 1'b1, 1'b0, 15'h0000, 2'b00, 3'b010, 4'hf, 32'h0);
    step; step;
    @(negedge clk);
    checks++;
    if (ack !== 2'b10) begin errors++; $display("[TB] FAIL async_pre_ack got %b want 10", ack); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 2'b00 || err !== 2'b00) begin errors++; $display("[TB] FAIL async_rst_ack got ack %b err %b want 00", ack, err); end
    checks++;
    if (dato !== '0) begin errors++; $display("[TB] FAIL async_rst_dat got %h want 0", dato); end
    rel(1);
    step;
    rst_n = 1'b1;
    step;
  endtask

  initial begin
    rel(0);
    rel(1);
    test_reset();
    test_classic_write_read();
    test_wrap4();
    test_round_robin();
    test_back_to_back();
    test_wait_abort();
    test_out_of_range();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
